// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Program-loader front end. It takes field-level instruction descriptions over
// a valid/ready handshake, encodes each one into a 32-bit MIPS word, and writes
// the word to the instruction memory at consecutive word addresses, starting at
// BASE_ADDR. Each accepted description costs two cycles: the accept edge, then
// one WRITE cycle with the memory strobe high.
//
// Parameters
//   BASE_ADDR  byte address of the first written word (word aligned)
//   DEPTH      capacity in words (1..255, since count_o is 8 bits)
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous active-low reset
//   clear_i     synchronous restart (address, count, flags, pending write)
//   in_valid_i  description present
//   in_ready_o  block can accept this cycle
//   kind_i      class: 0 RTYPE 1 ADDI 2 BEQ 3 ORI 4 LW 5 SW 6 J 7 illegal
//   rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i  instruction fields
//   im_we_o     instruction memory write strobe
//   im_addr_o   byte address of the write (registered, holds when idle)
//   im_data_o   encoded word (registered, holds when idle)
//   count_o     words written since reset/clear
//   full_o      count_o == DEPTH
//   err_o       sticky: an illegal class was received
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic [7:0]  count_o,
  output logic        full_o,
  output logic        err_o
);

  // class codes
  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_ADDI  = 3'd1;
  localparam logic [2:0] K_BEQ   = 3'd2;
  localparam logic [2:0] K_ORI   = 3'd3;
  localparam logic [2:0] K_LW    = 3'd4;
  localparam logic [2:0] K_SW    = 3'd5;
  localparam logic [2:0] K_J     = 3'd6;
  localparam logic [2:0] K_ILL   = 3'd7;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t      state, state_n;
  logic [31:0] addr_q;        // address the next accepted word will use
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic [7:0]  count_q;
  logic        full_q;
  logic        err_q;

  logic        restart;
  logic        xfer;
  logic        legal;
  logic [31:0] enc_word;

  // Reset and clear share one restart path; clear wins over any transfer.
  assign restart = !rst_i || clear_i;
  assign xfer    = in_valid_i && in_ready_o;
  assign legal   = (kind_i != K_ILL);

  // ---------------------------------------------------------------------------
  // Encoder. Fields not used by a class are simply not selected.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0;
    case (kind)
      K_RTYPE: w = {OP_RTYPE, rs, rt, rd, shamt, funct};
      K_ADDI:  w = {OP_ADDI, rs, rt, imm};
      K_BEQ:   w = {OP_BEQ,  rs, rt, imm};
      K_ORI:   w = {OP_ORI,  rs, rt, imm};
      K_LW:    w = {OP_LW,   rs, rt, imm};
      K_SW:    w = {OP_SW,   rs, rt, imm};
      K_J:     w = {OP_J, target};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign enc_word = encode(kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (restart) state <= IDLE;
    else         state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (xfer && legal) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs
  // The strobe is masked by a same-cycle clear/reset so a cancelled write is
  // never captured by the memory at the restart edge.
  always_comb begin
    in_ready_o = (state == IDLE) && !full_q && !clear_i;
    im_we_o    = (state == WRITE) && !restart;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (restart) begin
      addr_q    <= BASE_ADDR;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= 32'h0;
      count_q   <= 8'd0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (state == WRITE) begin
      // write completes at this edge
      addr_q  <= addr_q + 32'd4;
      count_q <= count_q + 8'd1;
      full_q  <= ((count_q + 8'd1) == DEPTH_W);
    end else if (xfer) begin
      if (legal) begin
        wr_addr_q <= addr_q;
        wr_data_q <= enc_word;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign im_addr_o = wr_addr_q;
  assign im_data_o = wr_data_q;
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder. Two instances share one stimulus bus: u0 with the
// default parameters and u1 with DEPTH=4, BASE_ADDR=0x100. A transaction-level
// model per instance predicts every output each cycle; writes seen on the
// memory port are logged and checked against hand-computed tables at the end.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic [1:0]       rdy, we, full, err;
  logic [1:0][31:0] addr, data;
  logic [1:0][7:0]  cnt;

  always #5 clk = ~clk;

  instr_encoder u0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(valid), .in_ready_o(rdy[0]),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
    .imm_i(imm), .target_i(target), .im_we_o(we[0]), .im_addr_o(addr[0]),
    .im_data_o(data[0]), .count_o(cnt[0]), .full_o(full[0]), .err_o(err[0])
  );

  instr_encoder #(.BASE_ADDR(32'h0000_0100), .DEPTH(4)) u1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(valid), .in_ready_o(rdy[1]),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
    .imm_i(imm), .target_i(target), .im_we_o(we[1]), .im_addr_o(addr[1]),
    .im_data_o(data[1]), .count_o(cnt[1]), .full_o(full[1]), .err_o(err[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] s, t, d, sh,
                                      input logic [5:0] fn, input logic [15:0] im,
                                      input logic [25:0] tg);
    logic [5:0] ops [7];
    ops = '{6'd0, 6'd8, 6'd4, 6'd13, 6'd35, 6'd43, 6'd2};
    if (k == 3'd0)      return {6'd0, s, t, d, sh, fn};
    else if (k == 3'd6) return {ops[6], tg};
    else                return {ops[k], s, t, im};
  endfunction

  int          depth [2] = '{128, 4};
  logic [31:0] base  [2] = '{32'h0, 32'h100};
  bit          pend  [2];
  bit          merr  [2];
  int          mcnt  [2];
  logic [31:0] mnext [2], mla [2], mld [2];

  function automatic bit mrdy(input int i);
    return !pend[i] && (mcnt[i] != depth[i]) && !clear;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst || clear) begin
        pend[i] <= 1'b0; merr[i] <= 1'b0; mcnt[i] <= 0;
        mnext[i] <= base[i]; mla[i] <= base[i]; mld[i] <= 32'h0;
      end else if (pend[i]) begin
        pend[i] <= 1'b0; mcnt[i] <= mcnt[i] + 1; mnext[i] <= mnext[i] + 32'd4;
      end else if (valid && mrdy(i)) begin
        if (kind == 3'd7) merr[i] <= 1'b1;
        else begin
          pend[i] <= 1'b1; mla[i] <= mnext[i];
          mld[i] <= enc(kind, rs, rt, rd, shamt, funct, imm, target);
        end
      end
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  bit          chk_en = 1'b0;
  logic [63:0] log0 [$], log1 [$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d ready", i), 64'(rdy[i]), 64'(mrdy(i)));
        chk($sformatf("u%0d we", i),    64'(we[i]),  64'(pend[i] && !clear && rst));
        chk($sformatf("u%0d addr", i),  64'(addr[i]), 64'(mla[i]));
        chk($sformatf("u%0d data", i),  64'(data[i]), 64'(mld[i]));
        chk($sformatf("u%0d count", i), 64'(cnt[i]),  64'(mcnt[i]));
        chk($sformatf("u%0d full", i),  64'(full[i]), 64'(mcnt[i] == depth[i]));
        chk($sformatf("u%0d err", i),   64'(err[i]),  64'(merr[i]));
      end
      if (we[0]) log0.push_back({addr[0], data[0]});
      if (we[1]) log1.push_back({addr[1], data[1]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] k, input logic [4:0] s, t, d, sh,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    int n;
    kind = k; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
    valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy[0]) break;
      n++;
      if (n > 20) begin
        tests++; fails++;
        $display("FAIL send_timeout: got ready 0 expected ready 1 within 20 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  logic [63:0] exp0 [11] = '{
    {32'h00, 32'h20080005},
    {32'h00, 32'h012A4020}, {32'h04, 32'h8FA80004}, {32'h08, 32'hAFA90008},
    {32'h0C, 32'h1109FFFF}, {32'h10, 32'h340800F0}, {32'h14, 32'h08000010},
    {32'h18, 32'h20080005},
    {32'h00, 32'h20080001}, {32'h04, 32'h20080002},
    {32'h00, 32'h340800F0}
  };
  logic [63:0] exp1 [8] = '{
    {32'h100, 32'h20080005},
    {32'h100, 32'h012A4020}, {32'h104, 32'h8FA80004}, {32'h108, 32'hAFA90008},
    {32'h10C, 32'h1109FFFF},
    {32'h100, 32'h20080001}, {32'h104, 32'h20080002},
    {32'h100, 32'h340800F0}
  };

  initial begin
    // pin the model encoder with hand-computed words
    chk("model enc addi", 64'(enc(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0)), 64'h20080005);
    chk("model enc j",    64'(enc(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10)),  64'h08000010);

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset ready",  64'(rdy),     64'h3);
    chk("reset addr0",  64'(addr[0]), 64'h0);
    chk("reset addr1",  64'(addr[1]), 64'h100);
    chk("reset data0",  64'(data[0]), 64'h0);
    chk("reset count0", 64'(cnt[0]),  64'h0);
    @(posedge clk); #1;

    // single ADDI
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    idle(2);
    chk("addi count0", 64'(cnt[0]), 64'd1);
    pulse_clear();

    // back-to-back; u1 fills after four
    send(3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'd0);
    @(negedge clk);
    chk("ready low in write", 64'(rdy[0]), 64'd0);
    send(3'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0);
    send(3'd5, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0);
    send(3'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    send(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h00F0, 26'd0);
    send(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10);
    idle(2);
    chk("b2b count0", 64'(cnt[0]),  64'd6);
    chk("u1 count",   64'(cnt[1]),  64'd4);
    chk("u1 full",    64'(full[1]), 64'd1);
    chk("u1 ready",   64'(rdy[1]),  64'd0);

    // illegal class
    send(3'd7, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h1);
    @(negedge clk);
    chk("illegal err0", 64'(err[0]), 64'd1);
    chk("illegal we0",  64'(we[0]),  64'd0);
    chk("illegal err1", 64'(err[1]), 64'd0);
    idle(1);
    chk("illegal count0", 64'(cnt[0]), 64'd6);
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    idle(2);
    pulse_clear();

    // clear during WRITE at count 2
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0);
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0);
    pulse_clear();
    @(negedge clk);
    chk("clear count0", 64'(cnt[0]), 64'd0);
    chk("clear err0",   64'(err[0]), 64'd0);
    chk("clear full1",  64'(full[1]), 64'd0);
    chk("clear we0",    64'(we[0]),  64'd0);
    @(posedge clk); #1;
    send(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h00F0, 26'd0);
    idle(2);

    // reset during WRITE
    send(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw we",    64'(we),      64'd0);
    chk("rstw ready", 64'(rdy),     64'h3);
    chk("rstw addr0", 64'(addr[0]), 64'h0);
    chk("rstw data0", 64'(data[0]), 64'h0);
    chk("rstw count0", 64'(cnt[0]), 64'h0);
    chk("rstw addr1", 64'(addr[1]), 64'h100);
    @(posedge clk); #1;

    // valid while clear held is not accepted
    kind = 3'd1; imm = 16'h0009;
    clear = 1'b1; valid = 1'b1;
    @(negedge clk);
    chk("clear ready", 64'(rdy), 64'd0);
    idle(3);
    valid = 1'b0; clear = 1'b0;
    idle(2);
    chk("clear+valid count0", 64'(cnt[0]), 64'd0);

    // write logs against hand-computed tables
    chk("log0 size", 64'(log0.size()), 64'd11);
    chk("log1 size", 64'(log1.size()), 64'd8);
    for (int i = 0; i < 11; i++)
      if (i < log0.size()) chk($sformatf("log0[%0d]", i), log0[i], exp0[i]);
    for (int i = 0; i < 8; i++)
      if (i < log1.size()) chk($sformatf("log1[%0d]", i), log1[i], exp1[i]);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
